// File: rtl/ddr_capture_packer.sv
// ddr_capture_packer: arms on Start, begins capture on a qualified trigger,
// packs three 16-bit samples into each 48-bit word for the DDR write FIFO
// stage, and counts words dropped while the FIFO reports full.
// Optional build macro TEST_PATTERN_EN adds the TestPat input, which swaps
// accepted samples for an internal ramp counter.
//
// state   | meaning
// IDLE    | waiting for Start
// ARMED   | length latched, waiting for SampleValid with TrigIn
// CAPTURE | packing samples into words until the latched length is reached
// DONE    | capture complete, samples ignored until Start or Abort
module ddr_capture_packer #(
    parameter int LEN_W = 32,
    parameter int OVF_W = 16
) (
    input  logic             WrClk,
    input  logic             Rst,
`ifdef TEST_PATTERN_EN
    input  logic             TestPat,
`endif
    input  logic [15:0]      SampleIn,
    input  logic             SampleValid,
    input  logic             Start,
    input  logic             Abort,
    input  logic             TrigIn,
    input  logic [LEN_W-1:0] CaptureWords,
    input  logic             FifoFull,
    output logic [47:0]      DataOut,
    output logic             DataOutValid,
    output logic             CaptureEn,
    output logic             Busy,
    output logic             Done,
    output logic [OVF_W-1:0] OvfCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [1:0]       r_lane;
    logic [15:0]      r_s0;
    logic [15:0]      r_s1;
    logic [47:0]      r_data;
    logic             r_valid;
    logic             r_cap_en;
    logic [OVF_W-1:0] r_ovf;
    logic [15:0]      w_sample;
    logic             w_accept;
    logic             w_word_done;
    logic             w_last;
    logic             w_start;

`ifdef TEST_PATTERN_EN
    logic [15:0]      r_pat;
    assign w_sample = TestPat ? r_pat : SampleIn;
`else
    assign w_sample = SampleIn;
`endif

    // The trigger sample itself is accepted into lane 0 (lane is cleared on Start).
    assign w_accept    = SampleValid && !Abort &&
                         ((r_state == ARMED && TrigIn) || r_state == CAPTURE);
    assign w_word_done = w_accept && (r_state == CAPTURE) && (r_lane == 2'd2);
    assign w_cnt_nxt   = r_cnt + LEN_W'(1);
    assign w_last      = w_word_done && (w_cnt_nxt == r_len);
    assign w_start     = Start && !Abort && (r_state == IDLE || r_state == DONE);

    // State register
    always_ff @(posedge WrClk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; Abort overrides everything, including Start
    always_comb begin
        w_next = r_state;
        if (Abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (Start) w_next = (CaptureWords == '0) ? DONE : ARMED;
                ARMED:      if (SampleValid && TrigIn) w_next = CAPTURE;
                CAPTURE:    if (w_last) w_next = DONE;
                default:    w_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        Busy = (r_state == ARMED) || (r_state == CAPTURE);
        Done = (r_state == DONE);
    end

    // Capture datapath: lane packing, word emission, counters
    always_ff @(posedge WrClk) begin
        if (Rst) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_lane   <= 2'd0;
            r_s0     <= 16'd0;
            r_s1     <= 16'd0;
            r_data   <= 48'd0;
            r_valid  <= 1'b0;
            r_cap_en <= 1'b0;
            r_ovf    <= '0;
        end else begin
            r_valid  <= 1'b0;
            // Stays high for the cycle the last word is presented
            r_cap_en <= (w_next == CAPTURE) || w_last;
            if (Abort) begin
                r_lane <= 2'd0;
            end else if (w_start) begin
                r_len  <= CaptureWords;
                r_cnt  <= '0;
                r_lane <= 2'd0;
                r_ovf  <= '0;
            end else if (w_accept) begin
                case (r_lane)
                    2'd0:    r_s0 <= w_sample;
                    2'd1:    r_s1 <= w_sample;
                    default: r_s0 <= r_s0;
                endcase
                r_lane <= (r_lane == 2'd2) ? 2'd0 : r_lane + 2'd1;
                if (w_word_done) begin
                    r_cnt <= w_cnt_nxt;
                    if (FifoFull) begin
                        if (r_ovf != '1) r_ovf <= r_ovf + OVF_W'(1);
                    end else begin
                        r_data  <= {w_sample, r_s1, r_s0};
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef TEST_PATTERN_EN
    // Ramp source: restarts at 0 on Start, steps once per accepted sample
    always_ff @(posedge WrClk) begin
        if (Rst)           r_pat <= 16'd0;
        else if (w_start)  r_pat <= 16'd0;
        else if (w_accept) r_pat <= r_pat + 16'd1;
    end
`endif

    assign DataOut      = r_data;
    assign DataOutValid = r_valid;
    assign CaptureEn    = r_cap_en;
    assign OvfCount     = r_ovf;

endmodule

// File: doc/ddr_capture_packer.md
Name: ddr_capture_packer

Overview:
Capture controller and sample packer in the WrClk domain, directly upstream of the DDR write FIFO stage. Accepts a 16-bit sample stream and arms on a software Start. Begins capture on a trigger and packs three samples into each 48-bit word. Drives the FIFO stage's data, valid and enable inputs for a programmed number of words, and counts words dropped while the FIFO reports full.

Parameters:
LEN_W, 32, width of the capture-length input and the internal word counter
OVF_W, 16, width of the saturating overflow (dropped-word) counter

Ports:
WrClk  in  1  write-domain clock; all logic on rising edge
Rst  in  1  reset, synchronous, active-high
SampleIn  in  16  input sample
SampleValid  in  1  SampleIn qualifier
Start  in  1  one-cycle pulse; arms a capture
Abort  in  1  one-cycle pulse; cancels any capture
TrigIn  in  1  trigger level, sampled only with SampleValid
CaptureWords  in  LEN_W  number of 48-bit words per capture; latched on Start
FifoFull  in  1  full flag from downstream FIFO stage
DataOut  out  48  packed word: sample0 [15:0], sample1 [31:16], sample2 [47:32]
DataOutValid  out  1  one-cycle strobe per written word
CaptureEn  out  1  enable to downstream stage
Busy  out  1  high in ARMED or CAPTURE
Done  out  1  high in DONE
OvfCount  out  OVF_W  words dropped due to FifoFull, saturating

Behaviour:
- Reset: state IDLE. DataOut=0, DataOutValid=0, CaptureEn=0, Busy=0, Done=0, OvfCount=0. Packer lane=0, word counter=0.
- States: IDLE, ARMED, CAPTURE, DONE.
- Start in IDLE or DONE: latch CaptureWords, clear OvfCount, word counter and lane, then go to ARMED. If the latched length is 0, go straight to DONE instead. Start in ARMED or CAPTURE is ignored.
- ARMED: when SampleValid=1 and TrigIn=1 on the same cycle, go to CAPTURE. That sample is stored in lane 0 (the trigger sample is captured). TrigIn is ignored when SampleValid=0.
- CAPTURE: each SampleValid stores SampleIn into the current lane, and the lane advances 0→1→2→0. Cycles without SampleValid hold the lane.
- Lane-2 sample accepted at edge N: the packed word appears on DataOut after edge N (one cycle of latency).
  - If FifoFull=0 at edge N, DataOutValid=1 for exactly that one cycle.
  - If FifoFull=1 at edge N, the word is dropped: DataOutValid stays 0 and OvfCount increments, saturating at all-ones.
- The word counter increments on every completed word, whether written or dropped, so capture duration is fixed.
- When the counter reaches the latched length, go to DONE on the same edge that emits the last word.
- CaptureEn is registered: 1 in CAPTURE and on the cycle the last word is presented; 0 otherwise.
- DataOut holds its last value when not valid.
- DONE: Done=1 and samples are ignored. Exit only on Start (to ARMED) or Abort (to IDLE).
- Abort in any state: go to IDLE at the next edge. The partial packer contents are discarded, no word is emitted that cycle, and Done/CaptureEn/Busy fall. OvfCount holds.
- Start and Abort on the same cycle: Abort wins.
- Rst mid-capture: same as reset; no partial word is emitted.
- Samples arriving in IDLE, ARMED (non-trigger) or DONE are ignored and the lane does not advance.

Optional Feature:
Macro TEST_PATTERN_EN.
- Defined: adds input port TestPat (1 bit). When TestPat=1, every accepted sample is replaced by a 16-bit internal counter. The counter is cleared on Start and increments per SampleValid accepted in CAPTURE, so word k = {3k+2, 3k+1, 3k}. All other behaviour is unchanged.
- Undefined: the port and counter are absent and SampleIn is always used.

Test Plan:
- Basic: CaptureWords=4, Start, then trigger on sample 0x0001 with continuous samples 0x0001..0x000C → four DataOutValid strobes; word0=0x0003_0002_0001, word3=0x000C_000B_000A; Done=1 afterwards; CaptureEn falls the cycle after the last strobe.
- Gapped input: SampleValid toggling 1,0,1,0… with CaptureWords=2 → identical words as dense input; each strobe one cycle after the lane-2 sample.
- Overflow: FifoFull=1 while the 2nd and 3rd of 5 words complete → 3 strobes, OvfCount=2, Done=1; with OVF_W=2 and 5 drops, OvfCount=3 (saturated).
- Abort: Abort after 1 word plus 2 lane samples → state IDLE next cycle, no further strobe, Busy=0, Done=0; subsequent Start+trigger yields a fresh word starting at lane 0.
- Edge cases: CaptureWords=0 with Start → Done=1 next cycle, no strobes. Start during CAPTURE is ignored. Start and Abort together → IDLE.
- TEST_PATTERN_EN: with TestPat=1 and CaptureWords=2 → words 0x0002_0001_0000, 0x0005_0004_0003 regardless of SampleIn.
